// File: rtl/fwd_pkg.sv
// Shared types for EX-stage operand forwarding: mux select codes, in-flight
// destination tags and the tag/source match rule.
package fwd_pkg;

  localparam int unsigned REG_AW_DFLT = 5;

  typedef enum logic [2:0] {
    SEL_RF        = 3'd0,
    SEL_EXMEM_ALU = 3'd1,
    SEL_MEMWB_ALU = 3'd2,
    SEL_MEMWB_LD  = 3'd3,
    SEL_WB_BYP    = 3'd4,
    SEL_IMM       = 3'd5,
    SEL_PC        = 3'd6,
    SEL_ZERO      = 3'd7
  } fwd_sel_e;

  typedef struct packed {
    logic                   valid;
    logic [REG_AW_DFLT-1:0] rd;
    logic                   reg_write;
    logic                   mem_read;
  } dst_tag_t;

  // x0 is hard-wired, so a producer targeting it never forwards.
  function automatic logic tag_hit(input dst_tag_t t, input logic [REG_AW_DFLT-1:0] rs);
    return t.valid && t.reg_write && (t.rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/fwd_src_pick.sv
// Combinational priority picker for one EX operand mux select.
// LOAD_FWD_EN: when defined, a load in MEM/WB forwards its data (code 3).
module fwd_src_pick
  import fwd_pkg::*;
#(
  parameter fwd_sel_e OVR_SEL = SEL_ZERO
) (
  input  logic [REG_AW_DFLT-1:0] rs_i,
  input  logic                   used_i,
  input  logic                   ovr_i,
  input  dst_tag_t               ex_tag_i,
  input  dst_tag_t               mem_tag_i,
  input  dst_tag_t               wb_tag_i,
  output fwd_sel_e               sel_o
);

  always_comb begin
    sel_o = SEL_RF;
    if (ovr_i) begin
      sel_o = OVR_SEL;
    end else if ((rs_i == '0) || !used_i) begin
      sel_o = SEL_ZERO;
    end else if (tag_hit(ex_tag_i, rs_i)) begin
      sel_o = SEL_EXMEM_ALU;
`ifdef LOAD_FWD_EN
    end else if (tag_hit(mem_tag_i, rs_i)) begin
      sel_o = mem_tag_i.mem_read ? SEL_MEMWB_LD : SEL_MEMWB_ALU;
`else
    // Load data is not forwardable from MEM/WB; the stall covers that case.
    end else if (tag_hit(mem_tag_i, rs_i) && !mem_tag_i.mem_read) begin
      sel_o = SEL_MEMWB_ALU;
`endif
    end else if (tag_hit(wb_tag_i, rs_i)) begin
      sel_o = SEL_WB_BYP;
    end
  end

endmodule

// File: rtl/ex_operand_fwd_ctrl.sv
// Registered EX operand mux selects plus load-use stall, driven by an internal
// EX/MEM/WB destination-tag pipeline. LOAD_FWD_EN selects 1-bubble load-use.
module ex_operand_fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_srca_pc,
  input  logic              id_srcb_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [2:0]        sel_a,
  output logic [2:0]        sel_b,
  output logic              ex_valid,
  output logic              stall
);

  dst_tag_t ex_tag_q, ex_tag_d, mem_tag_q, wb_tag_q;
  fwd_sel_e sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  fwd_sel_e pick_a, pick_b;
  logic     ex_valid_q, ex_valid_d;
  logic     hz_a, hz_b, kill;

  fwd_src_pick #(.OVR_SEL(SEL_PC)) u_pick_a (
    .rs_i      (id_rs1),
    .used_i    (id_rs1_used),
    .ovr_i     (id_srca_pc),
    .ex_tag_i  (ex_tag_q),
    .mem_tag_i (mem_tag_q),
    .wb_tag_i  (wb_tag_q),
    .sel_o     (pick_a)
  );

  fwd_src_pick #(.OVR_SEL(SEL_IMM)) u_pick_b (
    .rs_i      (id_rs2),
    .used_i    (id_rs2_used),
    .ovr_i     (id_srcb_imm),
    .ex_tag_i  (ex_tag_q),
    .mem_tag_i (mem_tag_q),
    .wb_tag_i  (wb_tag_q),
    .sel_o     (pick_b)
  );

  always_comb begin
    hz_a = id_rs1_used && tag_hit(ex_tag_q, id_rs1) && ex_tag_q.mem_read;
    hz_b = id_rs2_used && tag_hit(ex_tag_q, id_rs2) && ex_tag_q.mem_read;
`ifndef LOAD_FWD_EN
    // Without load forwarding the consumer also waits while the load is in MEM.
    hz_a = hz_a || (id_rs1_used && tag_hit(mem_tag_q, id_rs1) && mem_tag_q.mem_read);
    hz_b = hz_b || (id_rs2_used && tag_hit(mem_tag_q, id_rs2) && mem_tag_q.mem_read);
`endif
  end

  assign stall = id_valid && !flush && (hz_a || hz_b);
  assign kill  = stall || flush;

  always_comb begin
    ex_tag_d   = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
    sel_a_d    = pick_a;
    sel_b_d    = pick_b;
    ex_valid_d = id_valid;
    if (kill) begin
      ex_tag_d   = '0;
      sel_a_d    = SEL_RF;
      sel_b_d    = SEL_RF;
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_tag_q   <= '0;
      mem_tag_q  <= '0;
      wb_tag_q   <= '0;
      sel_a_q    <= SEL_RF;
      sel_b_q    <= SEL_RF;
      ex_valid_q <= 1'b0;
    end else begin
      ex_tag_q   <= ex_tag_d;
      mem_tag_q  <= ex_tag_q;
      wb_tag_q   <= mem_tag_q;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign sel_a    = sel_a_q;
  assign sel_b    = sel_b_q;
  assign ex_valid = ex_valid_q;

endmodule

// File: tb/tb_ex_operand_fwd_ctrl.sv
// Bench for ex_operand_fwd_ctrl: directed vector table, load-use/flush/reset
// sequences and randomized traffic against an instruction-history model.
module tb_ex_operand_fwd_ctrl;

`ifdef LOAD_FWD_EN
  localparam bit LFWD = 1'b1;
`else
  localparam bit LFWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs1_used, id_rs2_used, id_srca_pc, id_srcb_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, flush;
  logic [2:0] sel_a, sel_b;
  logic       ex_valid, stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_operand_fwd_ctrl #(.REG_AW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_srca_pc   (id_srca_pc),
    .id_srcb_imm  (id_srcb_imm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .ex_valid     (ex_valid),
    .stall        (stall)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       pc;
    logic       imm;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       fl;
  } in_t;

  typedef struct {
    in_t        i;
    logic [2:0] ea;
    logic [2:0] eb;
    logic       ev;
    logic       es;
  } vec_t;

  // Model: the last three instructions that entered EX, youngest first.
  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } mtag_t;

  mtag_t hist [3];

  function automatic in_t mk(logic valid, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                             logic pc, logic imm, logic [4:0] rd, logic wr, logic ld, logic fl);
    in_t x;
    x.valid = valid; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
    x.pc = pc; x.imm = imm; x.rd = rd; x.wr = wr; x.ld = ld; x.fl = fl;
    return x;
  endfunction

  function automatic vec_t mkv(in_t x, logic [2:0] ea, logic [2:0] eb, logic ev, logic es);
    vec_t v;
    v.i = x; v.ea = ea; v.eb = eb; v.ev = ev; v.es = es;
    return v;
  endfunction

  function automatic logic m_hit(int d, logic [4:0] rs);
    return hist[d].v && hist[d].wr && (hist[d].rd == rs) && (rs != 5'd0);
  endfunction

  // Nearest older producer wins: distance 1 -> EX/MEM, 2 -> MEM/WB, 3 -> WB bypass.
  function automatic logic [2:0] m_sel(logic [4:0] rs, logic used, logic ovr, logic [2:0] oc);
    if (ovr) return oc;
    if (rs == 5'd0 || !used) return 3'd7;
    for (int d = 0; d < 3; d++) begin
      if (m_hit(d, rs)) begin
        if (d == 0) return 3'd1;
        if (d == 1) begin
          if (!hist[1].ld) return 3'd2;
          if (LFWD) return 3'd3;
        end
        if (d == 2) return 3'd4;
      end
    end
    return 3'd0;
  endfunction

  function automatic logic m_stall(in_t x);
    logic h = 1'b0;
    for (int s = 0; s < 2; s++) begin
      logic [4:0] rs = (s == 0) ? x.rs1 : x.rs2;
      logic       u  = (s == 0) ? x.u1 : x.u2;
      if (u && ((m_hit(0, rs) && hist[0].ld) || (!LFWD && m_hit(1, rs) && hist[1].ld)))
        h = 1'b1;
    end
    return x.valid && !x.fl && h;
  endfunction

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic drive(in_t x);
    id_valid = x.valid; id_rs1 = x.rs1; id_rs1_used = x.u1; id_rs2 = x.rs2; id_rs2_used = x.u2;
    id_srca_pc = x.pc; id_srcb_imm = x.imm; id_rd = x.rd; id_reg_write = x.wr;
    id_mem_read = x.ld; flush = x.fl;
  endtask

  function automatic void model_clear();
    for (int d = 0; d < 3; d++) hist[d] = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
  endfunction

  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic step(input in_t x, output logic [2:0] a, output logic [2:0] b,
                      output logic ev, output logic st);
    logic       es, kill, eev;
    logic [2:0] ea, eb;
    drive(x);
    #4;
    es = m_stall(x);
    st = stall;
    chk("model_stall", stall, es);
    kill = es || x.fl;
    ea   = kill ? 3'd0 : m_sel(x.rs1, x.u1, x.pc, 3'd6);
    eb   = kill ? 3'd0 : m_sel(x.rs2, x.u2, x.imm, 3'd5);
    eev  = kill ? 1'b0 : x.valid;
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (kill) hist[0] = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
    else      hist[0] = '{v: x.valid, rd: x.rd, wr: x.wr, ld: x.ld};
    @(posedge clk);
    #1;
    chk("model_sel_a", sel_a, ea);
    chk("model_sel_b", sel_b, eb);
    chk("model_ex_valid", ex_valid, eev);
    a = sel_a; b = sel_b; ev = ex_valid;
  endtask

  initial begin
    vec_t       tbl [9];
    in_t        lw, dep, x;
    logic [2:0] a, b;
    logic       ev, st;

    tbl[0] = mkv(mk(1, 5'd1, 1, 5'd2, 1, 0, 0, 5'd5, 1, 0, 0), 3'd0, 3'd0, 1, 0);
    tbl[1] = mkv(mk(1, 5'd5, 1, 5'd3, 1, 0, 0, 5'd6, 1, 0, 0), 3'd1, 3'd0, 1, 0);
    tbl[2] = mkv(mk(1, 5'd5, 1, 5'd0, 1, 0, 0, 5'd8, 1, 0, 0), 3'd2, 3'd7, 1, 0);
    tbl[3] = mkv(mk(1, 5'd5, 1, 5'd5, 0, 0, 0, 5'd9, 1, 0, 0), 3'd4, 3'd7, 1, 0);
    tbl[4] = mkv(mk(1, 5'd5, 1, 5'd6, 1, 0, 0, 5'd10, 1, 0, 0), 3'd0, 3'd4, 1, 0);
    tbl[5] = mkv(mk(1, 5'd9, 1, 5'd10, 1, 1, 1, 5'd0, 1, 0, 0), 3'd6, 3'd5, 1, 0);
    tbl[6] = mkv(mk(1, 5'd0, 1, 5'd5, 1, 0, 0, 5'd11, 1, 0, 0), 3'd7, 3'd0, 1, 0);
    tbl[7] = mkv(mk(0, 5'd10, 1, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0), 3'd4, 3'd7, 0, 0);
    tbl[8] = mkv(mk(1, 5'd11, 1, 5'd10, 1, 0, 0, 5'd0, 0, 0, 0), 3'd2, 3'd0, 1, 0);

    lw  = mk(1, 5'd1, 1, 5'd0, 0, 0, 0, 5'd7, 1, 1, 0);
    dep = mk(1, 5'd2, 1, 5'd7, 1, 0, 0, 5'd13, 1, 0, 0);

    // Reset held two cycles with a valid instruction presented.
    reset = 1'b1;
    drive(mk(1, 5'd3, 1, 5'd4, 1, 0, 0, 5'd3, 1, 1, 0));
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_a", sel_a, 3'd0);
    chk("rst_sel_b", sel_b, 3'd0);
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    reset = 1'b0;

    foreach (tbl[k]) begin
      step(tbl[k].i, a, b, ev, st);
      chk("tbl_stall", st, tbl[k].es);
      chk("tbl_sel_a", a, tbl[k].ea);
      chk("tbl_sel_b", b, tbl[k].eb);
      chk("tbl_ex_valid", ev, tbl[k].ev);
    end

    // Load-use: dependent consumer is held in ID until the data is reachable.
    step(lw, a, b, ev, st);
    step(dep, a, b, ev, st);
    chk("lu_stall1", st, 1'b1);
    chk("lu_bubble1", ev, 1'b0);
    chk("lu_bubble1_sel_b", b, 3'd0);
    step(dep, a, b, ev, st);
    if (LFWD) begin
      chk("lu_stall2", st, 1'b0);
      chk("lu_sel_b", b, 3'd3);
      chk("lu_ex_valid", ev, 1'b1);
    end else begin
      chk("lu_stall2", st, 1'b1);
      chk("lu_bubble2", ev, 1'b0);
      step(dep, a, b, ev, st);
      chk("lu_stall3", st, 1'b0);
      chk("lu_sel_b", b, 3'd4);
      chk("lu_ex_valid", ev, 1'b1);
    end

    // Flush beats the hazard; the flushed slot must not forward its rd.
    step(lw, a, b, ev, st);
    x = dep; x.rd = 5'd12; x.fl = 1'b1;
    step(x, a, b, ev, st);
    chk("fl_stall", st, 1'b0);
    chk("fl_ex_valid", ev, 1'b0);
    chk("fl_sel_a", a, 3'd0);
    step(mk(1, 5'd12, 1, 5'd0, 0, 0, 0, 5'd14, 1, 0, 0), a, b, ev, st);
    chk("fl_nofwd_sel_a", a, 3'd0);
    chk("fl_nofwd_stall", st, 1'b0);
    chk("fl_nofwd_ex_valid", ev, 1'b1);

    // Reset asserted while a load-use stall is active.
    step(lw, a, b, ev, st);
    drive(dep);
    #4;
    chk("mid_stall_pre", stall, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_stall_rst", stall, 1'b0);
    chk("mid_ex_valid_rst", ex_valid, 1'b0);
    chk("mid_sel_b_rst", sel_b, 3'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_stall_post", stall, 1'b0);
    #3;
    step(dep, a, b, ev, st);
    chk("mid_dep_ex_valid", ev, 1'b1);
    chk("mid_dep_sel_b", b, 3'd0);

    for (int n = 0; n < 400; n++) begin
      x = mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 5) != 0,
             5'($urandom_range(0, 7)), $urandom_range(0, 5) != 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
             5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      step(x, a, b, ev, st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
